mem_arbiter: RTL

Arbitrates the single shared main-memory port (`memory4c`, one request per cycle, fixed read latency) between the instruction cache and the data cache. Line fills are sequenced here as bursts of word reads, and data-cache write-through stores as single-cycle writes. It replaces the combinational `sel` steering in the CPU top level. The block sits between `iCache`/`dCache` miss logic and `memory4c`.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 23 ++
 rtl/burst_seq.sv | 50 +++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU memory-system types: arbiter state encoding and line geometry
// defaults used by the arbiter and both caches.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    localparam int CPU_BURST_LEN = 8;
    localparam int CPU_MEM_LAT   = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Main-memory port bundle: the arbiter drives the request side (master),
// memory4c returns read data and its valid strobe (slave).
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );
endinterface

// File: rtl/burst_seq.sv
// Line-fill sequencer shared by both fill states: latches the line base and
// counts issued and returned words.
module burst_seq #(
    parameter int ADDR_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic                         issue_step,
    input  logic                         ret_step,
    output logic                         issue,
    output logic [ADDR_W-1:0]            addr,
    output logic [$clog2(BURST_LEN)-1:0] ret_idx,
    output logic                         last,
    output logic                         full
);
    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2 * BURST_LEN - 1);

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;

    always_ff @(posedge clk) begin
        if (start) base <= start_addr & ~LINE_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (start) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue_step && issue) issue_cnt <= issue_cnt + 1'b1;
            if (ret_step)            ret_cnt   <= ret_cnt + 1'b1;
        end
    end

    // Word offset is OR-ed into the cleared low bits so the burst never carries out of the line.
    assign issue   = issue_cnt < CNT_W'(BURST_LEN);
    assign addr    = base | ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
    assign ret_idx = ret_cnt[IDX_W-1:0];
    assign last    = ret_cnt == CNT_W'(BURST_LEN - 1);
    assign full    = ret_cnt == CNT_W'(BURST_LEN);
endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: dcache-over-icache fixed priority, non-preemptive
// line-fill bursts and single-cycle dcache write-through stores.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = CPU_BURST_LEN,
    parameter int MEM_LAT   = CPU_MEM_LAT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_grant,
    output logic                         i_valid,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         d_grant,
    output logic                         d_valid,
    output logic                         d_done,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(BURST_LEN)-1:0] rd_idx,
    output logic                         proto_err,
    mem_arbiter_if.master                mem
);
    localparam int IDX_W = $clog2(BURST_LEN);

    if (MEM_LAT < 1 || BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_params
        $error("mem_arbiter: BURST_LEN must be a power of two >= 2 and MEM_LAT >= 1");
    end

    arb_state_t        state;
    logic              in_fill, start_d_fill, start_i_fill, start_fill;
    logic [ADDR_W-1:0] start_addr, fill_addr;
    logic              issue, last, full, ret_ok, stray, fill_done;
    logic [IDX_W-1:0]  ret_idx;

    assign in_fill      = (state == I_FILL) || (state == D_FILL);
    assign start_d_fill = (state == IDLE) && d_req && !d_wr;
    assign start_i_fill = (state == IDLE) && !d_req && i_req;
    assign start_fill   = start_d_fill || start_i_fill;
    assign start_addr   = start_d_fill ? d_addr : i_addr;

    // Returns past the last word, or with no fill in progress, are dropped and flagged.
    assign ret_ok    = in_fill && mem.mem_valid && !full;
    assign stray     = mem.mem_valid && !ret_ok;
    assign fill_done = ret_ok && last;

    burst_seq #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_fill),
        .start_addr (start_addr),
        .issue_step (in_fill),
        .ret_step   (ret_ok),
        .issue      (issue),
        .addr       (fill_addr),
        .ret_idx    (ret_idx),
        .last       (last),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i_grant   <= 1'b0;
            d_grant   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (stray) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        state   <= d_wr ? D_WRITE : D_FILL;
                        d_grant <= 1'b1;
                    end else if (i_req) begin
                        state   <= I_FILL;
                        i_grant <= 1'b1;
                    end
                end
                I_FILL, D_FILL: begin
                    if (fill_done) begin
                        state   <= IDLE;
                        i_grant <= 1'b0;
                        d_grant <= 1'b0;
                    end
                end
                D_WRITE: begin
                    state   <= IDLE;
                    d_grant <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    i_grant <= 1'b0;
                    d_grant <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state == D_WRITE) begin
            mem.mem_en    = 1'b1;
            mem.mem_wr    = 1'b1;
            mem.mem_addr  = d_addr;
            mem.mem_wdata = d_wdata;
        end else if (in_fill && issue) begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = fill_addr;
        end
    end

    assign i_valid = (state == I_FILL) && ret_ok;
    assign d_valid = (state == D_FILL) && ret_ok;
    assign i_done  = (state == I_FILL) && fill_done;
    assign d_done  = ((state == D_FILL) && fill_done) || (state == D_WRITE);
    assign rd_idx  = ret_ok ? ret_idx : '0;
    assign rd_data = mem.mem_rdata;
endmodule
